mult_accum: RTL and testbench

- Downstream consumer of the combinational array multiplier's product bus `z`, width 2*DATA_WIDTH.
- Accepts one unsigned product per valid/ready beat and accumulates products into a wide register.
- A frame ends on the beat flagged last; the block then presents the frame sum, term count and overflow flag on a held output handshake.
- Sits between the multiplier array and the filter/dot-product logic that reads accumulated sums.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_accum_acc_add_sat.sv | 37 +++
 rtl/mult_accum.sv | 104 ++++++++++
 tb/tb_mult_accum.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the product accumulator.
//   state_t    - frame FSM encoding (ACCUM collects terms, HOLD presents a result)
//   prod_width - product bus width for a given multiplier operand width
//   acc_max    - all-ones value for an accumulator width (the clamp value)
package mult_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic int prod_width(input int data_width);
      return 2 * data_width;
   endfunction

   // Valid for widths up to 63 bits; callers cast down to their own width.
   function automatic logic [63:0] acc_max(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/mult_accum_acc_add_sat.sv
// acc_add_sat: combinational accumulator adder.
//   Adds a zero-extended product to the running sum and reports the carry out.
//   Build option MULT_ACCUM_SAT_EN: when defined, an overflowing add clamps the
//   sum to all-ones; when undefined, the sum wraps modulo 2^ACC_WIDTH.
// Ports:
//   acc   in  ACC_WIDTH   current running sum
//   prod  in  PROD_WIDTH  unsigned product to add
//   sum   out ACC_WIDTH   new running sum (wrapped or clamped)
//   carry out 1           the add exceeded 2^ACC_WIDTH-1
module acc_add_sat
   import mult_pkg::*;
#(
   parameter int ACC_WIDTH  = 40,
   parameter int PROD_WIDTH = 32
) (
   input  logic [ACC_WIDTH-1:0]  acc,
   input  logic [PROD_WIDTH-1:0] prod,
   output logic [ACC_WIDTH-1:0]  sum,
   output logic                  carry
);

   logic [ACC_WIDTH:0] full;

   assign full  = {1'b0, acc} + (ACC_WIDTH+1)'(prod);
   assign carry = full[ACC_WIDTH];

`ifdef MULT_ACCUM_SAT_EN
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));

   // Once clamped, every later add carries again, so the sum stays at ACC_MAX
   // for the rest of the frame without any extra state.
   assign sum = carry ? ACC_MAX : full[ACC_WIDTH-1:0];
`else
   assign sum = full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/mult_accum.sv
// mult_accum: accumulates unsigned multiplier products into frame sums.
//   One product is accepted per prod_valid & prod_ready beat. The beat flagged
//   prod_last closes the frame; its sum, term count and overflow flag are then
//   held on the acc_* handshake until acc_valid & acc_ready.
//   Build option MULT_ACCUM_SAT_EN selects clamping instead of wrapping on
//   overflow (see acc_add_sat); ports are identical in both builds.
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   prod_valid   in  product beat valid
//   prod_ready   out block accepts a product this cycle
//   prod_data    in  2*DATA_WIDTH unsigned product
//   prod_last    in  beat is the final term of the frame
//   acc_valid    out result valid, held until accepted
//   acc_ready    in  downstream accepts the result
//   acc_data     out ACC_WIDTH frame sum
//   acc_count    out CNT_WIDTH terms in frame, saturating
//   acc_ovf      out frame sum exceeded 2^ACC_WIDTH-1 (sticky per frame)
module mult_accum
   import mult_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            prod_valid,
   output logic                            prod_ready,
   input  logic [prod_width(DATA_WIDTH)-1:0] prod_data,
   input  logic                            prod_last,
   output logic                            acc_valid,
   input  logic                            acc_ready,
   output logic [ACC_WIDTH-1:0]            acc_data,
   output logic [CNT_WIDTH-1:0]            acc_count,
   output logic                            acc_ovf
);

   localparam int                   PROD_WIDTH = prod_width(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 ovf;

   logic [ACC_WIDTH-1:0] acc_next;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 ovf_next;
   logic                 carry;
   logic                 beat;

   // In HOLD a new beat may only enter in the same cycle the result is taken.
   assign prod_ready = (state == ACCUM) || acc_ready;
   assign beat       = prod_valid && prod_ready;
   assign acc_valid  = (state == HOLD);

   acc_add_sat #(
      .ACC_WIDTH  (ACC_WIDTH),
      .PROD_WIDTH (PROD_WIDTH)
   ) u_add (
      .acc   (acc),
      .prod  (prod_data),
      .sum   (acc_next),
      .carry (carry)
   );

   assign ovf_next = ovf || carry;
   assign cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_WIDTH'(1);

   // The running sum is cleared as soon as a frame closes, so it is already
   // zero throughout HOLD: a beat accepted alongside the result handoff starts
   // a fresh frame with no extra selection logic.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         acc_data  <= '0;
         acc_count <= '0;
         acc_ovf   <= 1'b0;
      end else if (beat) begin
         if (prod_last) begin
            acc_data  <= acc_next;
            acc_count <= cnt_next;
            acc_ovf   <= ovf_next;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= HOLD;
         end else begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            state <= ACCUM;
         end
      end else if (state == HOLD && acc_ready) begin
         state <= ACCUM;
      end
   end

endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum: directed self-checking bench for mult_accum with
// DATA_WIDTH=4, ACC_WIDTH=10, CNT_WIDTH=3. Inputs change 1 ns after a rising
// edge and outputs are sampled there too, away from the active edge.
module tb_mult_accum;

   logic       clk = 1'b0;
   logic       rst;
   logic       prod_valid;
   logic       prod_ready;
   logic [7:0] prod_data;
   logic       prod_last;
   logic       acc_valid;
   logic       acc_ready;
   logic [9:0] acc_data;
   logic [2:0] acc_count;
   logic       acc_ovf;

   int n_cmp = 0;
   int n_err = 0;

   mult_accum #(
      .DATA_WIDTH (4),
      .ACC_WIDTH  (10),
      .CNT_WIDTH  (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod_data  (prod_data),
      .prod_last  (prod_last),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .acc_data   (acc_data),
      .acc_count  (acc_count),
      .acc_ovf    (acc_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat presented for one cycle; caller ensures prod_ready is high.
   task automatic send(input logic [7:0] d, input logic l);
      prod_valid = 1'b1;
      prod_data  = d;
      prod_last  = l;
      tick();
      prod_valid = 1'b0;
      prod_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input int d, input int c, input int o);
      check({tag, ".valid"}, 32'(acc_valid), 32'd1);
      check({tag, ".data"},  32'(acc_data),  32'(d));
      check({tag, ".count"}, 32'(acc_count), 32'(c));
      check({tag, ".ovf"},   32'(acc_ovf),   32'(o));
   endtask

   int ovf_expect;

   initial begin
`ifdef MULT_ACCUM_SAT_EN
      ovf_expect = 1023;
`else
      ovf_expect = 101;
`endif
      // Reset with a beat offered: nothing may be absorbed.
      rst        = 1'b1;
      prod_valid = 1'b1;
      prod_data  = 8'd5;
      prod_last  = 1'b1;
      acc_ready  = 1'b1;
      tick();
      tick();
      check("rst.valid", 32'(acc_valid),  32'd0);
      check("rst.data",  32'(acc_data),   32'd0);
      check("rst.count", 32'(acc_count),  32'd0);
      check("rst.ovf",   32'(acc_ovf),    32'd0);
      check("rst.ready", 32'(prod_ready), 32'd1);
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      rst        = 1'b0;
      tick();
      check("idle.valid", 32'(acc_valid), 32'd0);

      // Three-term frame: 6 + 12 + 225 = 243.
      send(8'd6, 1'b0);
      check("f3.mid_valid", 32'(acc_valid), 32'd0);
      send(8'd12, 1'b0);
      send(8'd225, 1'b1);
      check_result("f3", 243, 3, 0);
      tick();
      check("f3.back_valid", 32'(acc_valid),  32'd0);
      check("f3.back_ready", 32'(prod_ready), 32'd1);

      // Backpressure: result 18 held, beat of 5 refused meanwhile.
      acc_ready = 1'b0;
      send(8'd9, 1'b0);
      send(8'd9, 1'b1);
      prod_valid = 1'b1;
      prod_data  = 8'd5;
      prod_last  = 1'b1;
      check("bp.ready_low", 32'(prod_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_result("bp.hold", 18, 2, 0);
         check("bp.hold_ready", 32'(prod_ready), 32'd0);
      end
      acc_ready = 1'b1;
      #1;
      check("bp.ready_high", 32'(prod_ready), 32'd1);
      tick();
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      check_result("bp.next", 5, 1, 0);
      tick();
      check("bp.back_valid", 32'(acc_valid), 32'd0);

      // Overflow: 5 x 225 = 1125 > 1023.
      for (int i = 0; i < 4; i++) send(8'd225, 1'b0);
      send(8'd225, 1'b1);
      check_result("ovf", ovf_expect, 5, 1);
      tick();

      // Count saturation: nine terms of 1; ovf must not leak from last frame.
      for (int i = 0; i < 8; i++) send(8'd1, 1'b0);
      send(8'd1, 1'b1);
      check_result("csat", 9, 7, 0);
      tick();

      // Reset mid-frame abandons the partial sum.
      send(8'd100, 1'b0);
      send(8'd100, 1'b0);
      rst = 1'b1;
      #1;
      check("mrst.valid", 32'(acc_valid), 32'd0);
      check("mrst.data",  32'(acc_data),  32'd0);
      check("mrst.count", 32'(acc_count), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      send(8'd7, 1'b1);
      check_result("mrst.frame", 7, 1, 0);
      tick();
      check("end.valid", 32'(acc_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
